// File: rtl/pio_rgb_pwm_pkg.sv
// Shared constants for the PIO / RGB PWM peripheral.
// Register word addresses, edge polarity codes, counter sizing.
package pio_rgb_pwm_pkg;

  localparam int unsigned A_DATA  = 0;
  localparam int unsigned A_MASK  = 1;
  localparam int unsigned A_CAP   = 2;
  localparam int unsigned A_POL   = 3;
  localparam int unsigned A_PRESC = 4;
  localparam int unsigned A_DUTY0 = 8;

  typedef enum logic [1:0] {
    POL_NONE = 2'b00,
    POL_RISE = 2'b01,
    POL_FALL = 2'b10,
    POL_BOTH = 2'b11
  } edge_pol_e;

  function automatic int deb_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pio_rgb_pwm_periph_debounce.sv
// One input channel: 2-FF synchroniser plus debounce filter.
// rise/fall pulse in the cycle the debounced value flips.
module pio_debounce
  import pio_rgb_pwm_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = deb_cnt_w(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          hit;

  assign hit  = (s2 != dout) && (cnt == CW'(DEB_CYCLES - 1));
  assign rise = hit & s2;
  assign fall = hit & ~s2;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Count stable disagreement; flip once it has lasted long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (s2 == dout) begin
      cnt <= '0;
    end else if (hit) begin
      cnt  <= '0;
      dout <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pio_rgb_pwm_periph.sv
// Avalon-MM PIO: debounced inputs with edge IRQ,
// plus per-colour PWM drive for a bank of RGB LEDs.
module pio_rgb_pwm_periph
  import pio_rgb_pwm_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int NUM_LED    = 4,
  parameter int PWM_W      = 8,
  parameter int DEB_CYCLES = 50000,
  parameter int ADDR_W     = 4
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [ADDR_W-1:0]    avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [3:0]           avs_byteenable,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 avs_readdatavalid,
  output logic                 avs_waitrequest,
  input  logic [NUM_IN-1:0]    in_export,
  output logic                 irq,
  output logic [3*NUM_LED-1:0] rgb_led_export
);

  localparam int unsigned PWM_TOP = (1 << PWM_W) - 2;

  int unsigned          addr_i;
  logic [31:0]          wm;
  logic [31:0]          wd;
  logic [31:0]          rd_val;
  logic [NUM_IN-1:0]    deb_state;
  logic [NUM_IN-1:0]    rise;
  logic [NUM_IN-1:0]    fall;
  logic [NUM_IN-1:0]    cap_set;
  logic [NUM_IN-1:0]    cap_clr;
  logic [NUM_IN-1:0]    irq_mask;
  logic [NUM_IN-1:0]    edge_cap;
  logic [2*NUM_IN-1:0]  edge_pol;
  logic [15:0]          presc;
  logic [15:0]          presc_cnt;
  logic [PWM_W-1:0]     pwm_cnt;
  logic [3*PWM_W-1:0]   duty   [NUM_LED];
  logic [3*PWM_W-1:0]   shadow [NUM_LED];
  logic                 tick;
  logic                 wr_mask;
  logic                 wr_cap;
  logic                 wr_pol;
  logic                 wr_presc;
  logic                 unused_ok;

  assign addr_i   = 32'(avs_address);
  assign wm       = {{8{avs_byteenable[3]}},
                     {8{avs_byteenable[2]}},
                     {8{avs_byteenable[1]}},
                     {8{avs_byteenable[0]}}};
  assign wd       = avs_writedata & wm;
  assign wr_mask  = avs_write && (addr_i == A_MASK);
  assign wr_cap   = avs_write && (addr_i == A_CAP);
  assign wr_pol   = avs_write && (addr_i == A_POL);
  assign wr_presc = avs_write && (addr_i == A_PRESC);
  assign tick     = (presc_cnt == presc);
  assign cap_clr  = wr_cap ? wd[NUM_IN-1:0] : '0;

  assign avs_waitrequest = 1'b0;
  assign unused_ok       = ^wd;

  for (genvar c = 0; c < NUM_IN; c++) begin : g_deb
    pio_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk_clk),
      .rst_n(reset_reset_n),
      .din  (in_export[c]),
      .dout (deb_state[c]),
      .rise (rise[c]),
      .fall (fall[c])
    );
  end

  // Qualify debounced edges with each channel's polarity code.
  always_comb begin
    cap_set = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      unique case (edge_pol[2*c +: 2])
        POL_RISE: cap_set[c] = rise[c];
        POL_FALL: cap_set[c] = fall[c];
        POL_BOTH: cap_set[c] = rise[c] | fall[c];
        default:  cap_set[c] = 1'b0;
      endcase
    end
  end

  // Read mux; holes and unimplemented bits return zero.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      addr_i == A_DATA:  rd_val[NUM_IN-1:0]   = deb_state;
      addr_i == A_MASK:  rd_val[NUM_IN-1:0]   = irq_mask;
      addr_i == A_CAP:   rd_val[NUM_IN-1:0]   = edge_cap;
      addr_i == A_POL:   rd_val[2*NUM_IN-1:0] = edge_pol;
      addr_i == A_PRESC: rd_val[15:0]         = presc;
      default: begin
        for (int i = 0; i < NUM_LED; i++) begin
          if (addr_i == A_DUTY0 + unsigned'(i)) begin
            for (int c = 0; c < 3; c++) begin
              rd_val[8*c +: PWM_W] = duty[i][c*PWM_W +: PWM_W];
            end
          end
        end
      end
    endcase
  end

  // Plain RW registers with per-byte write enables.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_mask <= '0;
      edge_pol <= '0;
      presc    <= '0;
      for (int i = 0; i < NUM_LED; i++) begin
        duty[i] <= '0;
      end
    end else begin
      if (wr_mask) begin
        irq_mask <= (irq_mask & ~wm[NUM_IN-1:0])
                  | wd[NUM_IN-1:0];
      end
      if (wr_pol) begin
        edge_pol <= (edge_pol & ~wm[2*NUM_IN-1:0])
                  | wd[2*NUM_IN-1:0];
      end
      if (wr_presc) begin
        presc <= (presc & ~wm[15:0]) | wd[15:0];
      end
      for (int i = 0; i < NUM_LED; i++) begin
        if (avs_write &&
            addr_i == A_DUTY0 + unsigned'(i)) begin
          for (int c = 0; c < 3; c++) begin
            if (avs_byteenable[c]) begin
              duty[i][c*PWM_W +: PWM_W] <=
                avs_writedata[8*c +: PWM_W];
            end
          end
        end
      end
    end
  end

  // Edge capture (a new edge beats W1C) and registered IRQ.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  // Registered read data, valid one cycle after the strobe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_val;
      end
    end
  end

  // Prescaler tick and PWM period counter; duty shadows load on wrap.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      for (int i = 0; i < NUM_LED; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      if (wr_presc || tick) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + 16'd1;
      end
      if (tick) begin
        if (pwm_cnt == PWM_W'(PWM_TOP)) begin
          pwm_cnt <= '0;
          for (int i = 0; i < NUM_LED; i++) begin
            shadow[i] <= duty[i];
          end
        end else begin
          pwm_cnt <= pwm_cnt + 1'b1;
        end
      end
    end
  end

  // Registered colour compare against the shadowed duty.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rgb_led_export <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        for (int c = 0; c < 3; c++) begin
          rgb_led_export[3*i+c] <=
            pwm_cnt < shadow[i][c*PWM_W +: PWM_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_pio_rgb_pwm_periph.sv
// Bench for pio_rgb_pwm_periph: directed cases plus random traffic,
// checked every cycle against a behavioural model.
module tb_pio_rgb_pwm_periph;

  localparam int NI   = 4;
  localparam int NL   = 4;
  localparam int PW   = 8;
  localparam int DEB  = 8;
  localparam int AW   = 4;
  localparam int PMAX = (1 << PW) - 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [AW-1:0]   avs_address = '0;
  logic            avs_read = 1'b0;
  logic            avs_write = 1'b0;
  logic [3:0]      avs_byteenable = '0;
  logic [31:0]     avs_writedata = '0;
  logic [31:0]     avs_readdata;
  logic            avs_readdatavalid;
  logic            avs_waitrequest;
  logic [NI-1:0]   in_export = '0;
  logic            irq;
  logic [3*NL-1:0] rgb_led_export;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pio_rgb_pwm_periph #(
    .NUM_IN(NI), .NUM_LED(NL), .PWM_W(PW),
    .DEB_CYCLES(DEB), .ADDR_W(AW)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_byteenable   (avs_byteenable),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest  (avs_waitrequest),
    .in_export        (in_export),
    .irq              (irq),
    .rgb_led_export   (rgb_led_export)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h at %0t",
                  nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [NI-1:0]   m_deb, m_mask, m_cap;
  logic [2*NI-1:0] m_pol;
  logic [15:0]     m_presc, m_ph;
  logic [PW-1:0]   m_duty [NL][3];
  logic [PW-1:0]   m_shd  [NL][3];
  logic [NI-1:0]   m_samp [0:DEB];
  int              m_pos;
  logic [3*NL-1:0] m_led;
  logic            m_irq, m_rdv;
  logic [31:0]     m_rdata;

  function automatic logic [31:0] m_reg(input int a);
    logic [31:0] v;
    v = '0;
    case (a)
      0: v[NI-1:0]   = m_deb;
      1: v[NI-1:0]   = m_mask;
      2: v[NI-1:0]   = m_cap;
      3: v[2*NI-1:0] = m_pol;
      4: v[15:0]     = m_presc;
      default:
        if (a >= 8 && a < 8 + NL)
          for (int c = 0; c < 3; c++)
            v[8*c +: PW] = m_duty[a-8][c];
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [NI-1:0] flip, nd, setb, clr;
    logic [31:0]   wm, wd;
    logic          all1, tick;
    int            a;
    if (!rst_n) begin
      m_deb <= '0; m_mask <= '0; m_cap <= '0;
      m_pol <= '0; m_presc <= '0; m_ph <= '0;
      m_pos <= 0; m_led <= '0; m_irq <= 1'b0;
      m_rdv <= 1'b0; m_rdata <= '0;
      for (int k = 0; k <= DEB; k++) m_samp[k] <= '0;
      for (int i = 0; i < NL; i++)
        for (int c = 0; c < 3; c++) begin
          m_duty[i][c] <= '0;
          m_shd[i][c]  <= '0;
        end
    end else begin
      a = int'(avs_address);
      // flip when the last DEB synchronised samples all disagree
      for (int c = 0; c < NI; c++) begin
        all1 = 1'b1;
        for (int k = 1; k <= DEB; k++)
          if (m_samp[k][c] == m_deb[c]) all1 = 1'b0;
        flip[c] = all1;
      end
      nd = m_deb ^ flip;
      for (int c = 0; c < NI; c++)
        setb[c] = (flip[c] & nd[c] & m_pol[2*c])
                | (flip[c] & ~nd[c] & m_pol[2*c+1]);
      for (int b = 0; b < 4; b++)
        wm[8*b +: 8] = {8{avs_byteenable[b]}};
      wd  = avs_writedata & wm;
      clr = '0;
      m_rdv <= avs_read;
      if (avs_read) m_rdata <= m_reg(a);
      if (avs_write) begin
        if (a == 1) m_mask <= (m_mask & ~wm[NI-1:0]) | wd[NI-1:0];
        if (a == 2) clr = wd[NI-1:0];
        if (a == 3)
          m_pol <= (m_pol & ~wm[2*NI-1:0]) | wd[2*NI-1:0];
        if (a == 4) m_presc <= (m_presc & ~wm[15:0]) | wd[15:0];
        if (a >= 8 && a < 8 + NL)
          for (int c = 0; c < 3; c++)
            if (avs_byteenable[c])
              m_duty[a-8][c] <= avs_writedata[8*c +: PW];
      end
      m_cap <= (m_cap & ~clr) | setb;
      m_irq <= |(m_cap & m_mask);
      m_deb <= nd;
      for (int k = DEB; k >= 1; k--) m_samp[k] <= m_samp[k-1];
      m_samp[0] <= in_export;
      for (int i = 0; i < NL; i++)
        for (int c = 0; c < 3; c++)
          m_led[3*i+c] <= (m_pos < int'(m_shd[i][c]));
      tick = (m_ph == m_presc);
      if ((avs_write && a == 4) || tick) m_ph <= '0;
      else m_ph <= m_ph + 16'd1;
      if (tick) begin
        if (m_pos == PMAX) begin
          m_pos <= 0;
          for (int i = 0; i < NL; i++)
            for (int c = 0; c < 3; c++)
              m_shd[i][c] <= m_duty[i][c];
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("led", 32'(rgb_led_export), 32'(m_led));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("rdv", 32'(avs_readdatavalid), 32'(m_rdv));
      if (m_rdv) chk("rdata", avs_readdata, m_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [3:0] be,
                    input logic [31:0] d);
    avs_address = AW'(a); avs_byteenable = be;
    avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd_lit(input int a, input logic [31:0] exp,
                        input string nm);
    avs_address = AW'(a); avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    chk({nm, "_rdv"}, 32'(avs_readdatavalid), 32'd1);
    chk(nm, avs_readdata, exp);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cr, cg, cb;
    int rst_addrs [6] = '{0, 1, 2, 3, 4, 8};
    #1 rst_n = 1'b0;
    idle(3);
    chk("rst_led", 32'(rgb_led_export), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdv", 32'(avs_readdatavalid), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("waitrequest", 32'(avs_waitrequest), 32'd0);
    foreach (rst_addrs[i]) rd_lit(rst_addrs[i], 32'd0, "rst_read");
    idle(1);
    chk("rdv_single", 32'(avs_readdatavalid), 32'd0);

    // channel 0: rising polarity, IRQ enabled
    wr(3, 4'hF, 32'h1);
    wr(1, 4'hF, 32'h1);
    in_export[0] = 1'b1; idle(3); in_export[0] = 1'b0;
    idle(15);
    rd_lit(0, 32'd0, "glitch_data");
    in_export[0] = 1'b1;
    idle(9);
    rd_lit(0, 32'd0, "data_before");
    chk("irq_before", 32'(irq), 32'd0);
    rd_lit(0, 32'd1, "data_after");
    chk("irq_after", 32'(irq), 32'd1);
    rd_lit(2, 32'd1, "cap_set");
    wr(2, 4'hF, 32'h1);
    idle(1);
    chk("irq_w1c", 32'(irq), 32'd0);

    // W1C in the same cycle as a new matching edge
    in_export[0] = 1'b0; idle(15);
    in_export[0] = 1'b1; idle(9);
    wr(2, 4'hF, 32'h1);
    rd_lit(2, 32'd1, "cap_set_wins");
    wr(2, 4'hF, 32'hF);

    // channel 1: falling only, then both
    wr(3, 4'hF, 32'h9);
    in_export[1] = 1'b1; idle(14);
    rd_lit(2, 32'd0, "pol_fall_rise");
    in_export[1] = 1'b0; idle(14);
    rd_lit(2, 32'd2, "pol_fall_fall");
    wr(2, 4'hF, 32'h2);
    wr(3, 4'hF, 32'hD);
    in_export[1] = 1'b1; idle(14);
    rd_lit(2, 32'd2, "pol_both_rise");
    wr(2, 4'hF, 32'h2);
    in_export[1] = 1'b0; idle(14);
    rd_lit(2, 32'd2, "pol_both_fall");
    wr(2, 4'hF, 32'hF);

    // register map edges
    wr(12, 4'hF, 32'hFFFF_FFFF);
    rd_lit(12, 32'd0, "unmapped");
    wr(1, 4'hF, 32'hFFFF_FFFF);
    rd_lit(1, 32'hF, "mask_bits");
    wr(1, 4'hF, 32'h1);

    // PWM brightness over one full period
    wr(4, 4'hF, 32'h0);
    wr(8, 4'hF, 32'h00FF_4000);
    idle(300);
    cr = 0; cg = 0; cb = 0;
    repeat (255) begin
      cr += int'(rgb_led_export[0]);
      cg += int'(rgb_led_export[1]);
      cb += int'(rgb_led_export[2]);
      @(negedge clk);
    end
    chk("pwm_r_cnt", 32'(cr), 32'd0);
    chk("pwm_g_cnt", 32'(cg), 32'd64);
    chk("pwm_b_cnt", 32'(cb), 32'd255);
    idle(100);
    wr(8, 4'h2, 32'h0000_1000);
    idle(300);
    cg = 0;
    repeat (255) begin
      cg += int'(rgb_led_export[1]);
      @(negedge clk);
    end
    chk("pwm_g_new", 32'(cg), 32'd16);
    wr(9, 4'hF, 32'h0011_2233);
    wr(9, 4'h2, 32'h00AA_BBCC);
    rd_lit(9, 32'h0011_BB33, "duty1_be");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      if ($urandom_range(0, 9) == 0) in_export = NI'($urandom);
      r = $urandom_range(0, 9);
      avs_read       = (r < 3);
      avs_write      = (r >= 2 && r < 5);
      avs_address    = AW'($urandom_range(0, 15));
      avs_byteenable = 4'($urandom);
      avs_writedata  = $urandom;
      if (avs_address == AW'(4))
        avs_writedata = $urandom_range(0, 3);
      @(negedge clk);
    end
    avs_read = 1'b0; avs_write = 1'b0;

    // async reset while LEDs are lit
    wr(4, 4'hF, 32'h0);
    wr(10, 4'hF, 32'h00FF_FFFF);
    idle(300);
    chk("led2_on", 32'(rgb_led_export[8:6]), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(rgb_led_export), 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
